// File: rtl/adder_bist_ctrl.sv
// rtl/adder_bist_ctrl.sv - exhaustive self-test sweep and checker for a W-bit adder
// Optional STOP_ON_FAIL_EN: end the run at the first mismatching vector.
module adder_bist_ctrl #(
  parameter int W       = 4,
  parameter int DUT_LAT = 0,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     dut_a,
  output logic [W-1:0]     dut_b,
  output logic             dut_cin,
  input  logic [W-1:0]     dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2*W:0]     fail_vec,
  output logic [W:0]       fail_got
);

  localparam int VW = 2 * W + 1;
  localparam logic [VW-1:0]    VEC_LAST = {VW{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [2:0]       LAT_LAST = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  state_t        state;
  logic [VW-1:0] vec;
  logic [2:0]    wait_cnt;
  logic          mism_seen;
  logic [W:0]    exp_sum;
  logic [W:0]    got;
  logic          mism;
  logic          last;

  // Operands come straight from the vector register, so they are registered
  // and cannot move between DRIVE and CHECK.
  assign {dut_a, dut_b, dut_cin} = vec;

  always_comb begin
    exp_sum = {1'b0, dut_a} + {1'b0, dut_b} + {{W{1'b0}}, dut_cin};
    got     = {dut_cout, dut_sum};
    mism    = (got !== exp_sum);
`ifdef STOP_ON_FAIL_EN
    last    = (vec == VEC_LAST) || mism;
`else
    last    = (vec == VEC_LAST);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      wait_cnt  <= '0;
      mism_seen <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_vec  <= '0;
      fail_got  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec       <= '0;
            mism_seen <= 1'b0;
            err_cnt   <= '0;
            fail_vec  <= '0;
            fail_got  <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          wait_cnt <= '0;
          state    <= (DUT_LAT == 0) ? CHECK : WAIT;
        end
        WAIT: begin
          if (wait_cnt == LAT_LAST) state <= CHECK;
          else wait_cnt <= wait_cnt + 3'd1;
        end
        CHECK: begin
          if (mism) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + 1'b1;
            if (!mism_seen) begin
              fail_vec <= vec;
              fail_got <= got;
            end
            mism_seen <= 1'b1;
          end
          if (last) begin
            // sticky flag keeps a saturated counter from reading as a pass
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= !mism && !mism_seen && (err_cnt == '0);
            state <= DONE;
          end else begin
            vec   <= vec + 1'b1;
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// tb/tb_adder_bist_ctrl.sv - scoreboard bench for adder_bist_ctrl with fault-injectable adder models
module tb_adder_bist_ctrl;

  typedef struct {
    int         lat;
    logic       pass;
    logic [7:0] err;
    logic [8:0] fv;
    logic [4:0] fg;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [3:0] a0, b0, sum0, a1, b1, sum1;
  logic cin0, cout0, cin1, cout1;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [7:0] err0, err1;
  logic [8:0] fv0, fv1;
  logic [4:0] fg0, fg1;
  logic [4:0] raw0, raw1, p1, p2, q1, q2, o0;
  int mode = 0;
  int cyc = 0;
  int start_cyc0 = 0, start_cyc1 = 0;
  int n_checks = 0, n_fail = 0;
  logic done0_q = 1'b0, done1_q = 1'b0;
  exp_t q0[$], qq1[$];
  exp_t e0m, e1m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_bist_ctrl #(.W(4), .DUT_LAT(0), .ERR_W(8)) u_lat0 (
    .clk(clk), .rst(rst), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_cin(cin0), .dut_sum(sum0), .dut_cout(cout0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .fail_vec(fv0), .fail_got(fg0)
  );

  adder_bist_ctrl #(.W(4), .DUT_LAT(2), .ERR_W(8)) u_lat2 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_sum(sum1), .dut_cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_vec(fv1), .fail_got(fg1)
  );

  // Adder models: 0 good, 1 sum[0] stuck-at-0, 2 two-stage registered, 3 sum[3] flipped at a=b=15
  always_comb begin
    raw0 = {1'b0, a0} + {1'b0, b0} + {4'd0, cin0};
    raw1 = {1'b0, a1} + {1'b0, b1} + {4'd0, cin1};
    case (mode)
      1:       o0 = raw0 & 5'b11110;
      2:       o0 = p2;
      3:       o0 = (a0 == 4'd15 && b0 == 4'd15) ? (raw0 ^ 5'b01000) : raw0;
      default: o0 = raw0;
    endcase
    {cout0, sum0} = o0;
    {cout1, sum1} = q2;
  end

  always @(posedge clk) begin
    if (rst) begin
      p1 <= 5'd0; p2 <= 5'd0; q1 <= 5'd0; q2 <= 5'd0;
    end else begin
      p1 <= raw0; p2 <= p1; q1 <= raw1; q2 <= q1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic exp_t mk(input int lat, input logic p, input int err, input int fv, input int fg);
    exp_t e;
    e.lat = lat; e.pass = p; e.err = 8'(err); e.fv = 9'(fv); e.fg = 5'(fg);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done0 && !done0_q) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done0: got done=1 expected no run");
      end else begin
        e0m = q0.pop_front();
        chk("lat0", cyc - start_cyc0, e0m.lat);
        chk("pass0", {31'd0, pass0}, {31'd0, e0m.pass});
        chk("err0", {24'd0, err0}, {24'd0, e0m.err});
        chk("fail_vec0", {23'd0, fv0}, {23'd0, e0m.fv});
        chk("fail_got0", {27'd0, fg0}, {27'd0, e0m.fg});
        chk("busy0_at_done", {31'd0, busy0}, 0);
      end
    end
    done0_q = done0;
  end

  always @(negedge clk) begin
    if (done1 && !done1_q) begin
      if (qq1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done1: got done=1 expected no run");
      end else begin
        e1m = qq1.pop_front();
        chk("lat1", cyc - start_cyc1, e1m.lat);
        chk("pass1", {31'd0, pass1}, {31'd0, e1m.pass});
        chk("err1", {24'd0, err1}, {24'd0, e1m.err});
        chk("fail_vec1", {23'd0, fv1}, {23'd0, e1m.fv});
      end
    end
    done1_q = done1;
  end

  task automatic pulse0(input exp_t e);
    @(negedge clk);
    start0 = 1'b1;
    q0.push_back(e);
    @(negedge clk);
    start_cyc0 = cyc;
    start0 = 1'b0;
  endtask

  task automatic wait_q0(input int budget);
    int n = 0;
    while (q0.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout0: got no done within %0d cycles expected done", budget);
      q0.delete();
    end
  endtask

  task automatic chk_reset0();
    chk("rst_busy", {31'd0, busy0}, 0);
    chk("rst_done", {31'd0, done0}, 0);
    chk("rst_pass", {31'd0, pass0}, 0);
    chk("rst_err", {24'd0, err0}, 0);
    chk("rst_fail_vec", {23'd0, fv0}, 0);
    chk("rst_fail_got", {27'd0, fg0}, 0);
    chk("rst_operands", {23'd0, a0, b0, cin0}, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_reset0();
    rst = 1'b0;

    // T1 on the combinational instance alongside T4 on the latency-2 instance
    @(negedge clk);
    start0 = 1'b1; start1 = 1'b1;
    q0.push_back(mk(1024, 1'b1, 0, 0, 0));
    qq1.push_back(mk(2048, 1'b1, 0, 0, 0));
    @(negedge clk);
    start_cyc0 = cyc; start_cyc1 = cyc;
    start0 = 1'b0; start1 = 1'b0;
    wait_q0(3000);
    n = 0;
    while (qq1.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (qq1.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout1: got no done within 3000 cycles expected done");
      qq1.delete();
    end

    // T2: sum[0] stuck-at-0, restarted from DONE
    mode = 1;
`ifdef STOP_ON_FAIL_EN
    pulse0(mk(4, 1'b0, 1, 1, 0));
`else
    pulse0(mk(1024, 1'b0, 255, 1, 0));
`endif
    wait_q0(3000);

    // only the last two vectors fail: exp 30, bit 3 flipped gives 22
    mode = 3;
`ifdef STOP_ON_FAIL_EN
    pulse0(mk(1022, 1'b0, 1, 510, 22));
`else
    pulse0(mk(1024, 1'b0, 2, 510, 22));
`endif
    wait_q0(3000);

    // T6: start held through the run must not restart it
    mode = 0;
    @(negedge clk);
    start0 = 1'b1;
    q0.push_back(mk(1024, 1'b1, 0, 0, 0));
    @(negedge clk);
    start_cyc0 = cyc;
    repeat (500) @(negedge clk);
    chk("busy0_mid_run", {31'd0, busy0}, 1);
    repeat (500) @(negedge clk);
    start0 = 1'b0;
    wait_q0(3000);
    pulse0(mk(1024, 1'b1, 0, 0, 0));
    wait_q0(3000);

    // T5: reset mid-run at vec=100
    pulse0(mk(1024, 1'b1, 0, 0, 0));
    n = 0;
    while ({a0, b0, cin0} != 9'd100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_vec100", {23'd0, a0, b0, cin0}, 100);
    rst = 1'b1;
    @(negedge clk);
    q0.delete();
    chk_reset0();
    rst = 1'b0;

    // registered DUT behind the zero-latency instance always reads the previous vector
    mode = 2;
`ifdef STOP_ON_FAIL_EN
    pulse0(mk(4, 1'b0, 1, 1, 0));
`else
    pulse0(mk(1024, 1'b0, 255, 1, 0));
`endif
    wait_q0(3000);

    mode = 0;
    pulse0(mk(1024, 1'b1, 0, 0, 0));
    wait_q0(3000);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

endmodule
